// File: rtl/vga_timing_gen.sv
// vga_timing_gen
//   Parametrised VGA timing generator and registered pixel output stage.
//   A clock divider produces a one-clk pixel enable; horizontal and vertical
//   counters run over the configured mode and present the current coordinate
//   to the renderer. Sync and colour are registered on the pixel enable from
//   the pre-increment coordinate, so they lag the coordinate by one pixel tick.
//
//   Optional feature macro: VGA_TEST_PATTERN_EN (adds test_en and an
//   eight-bar colour pattern over the active area).
//
// Ports
//   clk          system clock, rising edge
//   rst_n        asynchronous active-low reset
//   r_in/g_in/b_in  renderer colour for (pix_x, pix_y)
//   test_en      (VGA_TEST_PATTERN_EN only) replace renderer colour by bars
//   pix_x/pix_y  current coordinate
//   pix_valid    coordinate lies in the active area
//   pix_ce       one-clk pixel enable
//   line_start   pulse in the clk where pix_x becomes 0
//   frame_start  pulse in the clk where pix_x and pix_y become 0
//   hsync/vsync  registered sync outputs
//   r/g/b        registered colour, zero while blanked
module vga_timing_gen #(
   parameter int unsigned CLK_DIV   = 2,
   parameter int unsigned H_ACTIVE  = 640,
   parameter int unsigned H_FP      = 16,
   parameter int unsigned H_SYNC    = 96,
   parameter int unsigned H_BP      = 48,
   parameter int unsigned V_ACTIVE  = 480,
   parameter int unsigned V_FP      = 10,
   parameter int unsigned V_SYNC    = 2,
   parameter int unsigned V_BP      = 33,
   parameter bit          HSYNC_POL = 1'b0,
   parameter bit          VSYNC_POL = 1'b0,
   parameter int unsigned COLOR_W   = 2,
   localparam int unsigned H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP,
   localparam int unsigned V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP,
   localparam int unsigned X_W      = $clog2(H_TOTAL),
   localparam int unsigned Y_W      = $clog2(V_TOTAL)
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [COLOR_W-1:0] r_in,
   input  logic [COLOR_W-1:0] g_in,
   input  logic [COLOR_W-1:0] b_in,
`ifdef VGA_TEST_PATTERN_EN
   input  logic               test_en,
`endif
   output logic [X_W-1:0]     pix_x,
   output logic [Y_W-1:0]     pix_y,
   output logic               pix_valid,
   output logic               pix_ce,
   output logic               line_start,
   output logic               frame_start,
   output logic               hsync,
   output logic               vsync,
   output logic [COLOR_W-1:0] r,
   output logic [COLOR_W-1:0] g,
   output logic [COLOR_W-1:0] b
);

   localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int unsigned BAR_W = (H_ACTIVE >= 8) ? H_ACTIVE / 8 : 1;

   logic [DIV_W-1:0]   div_q, div_d;
   logic [X_W-1:0]     pix_x_q, pix_x_d;
   logic [Y_W-1:0]     pix_y_q, pix_y_d;
   logic               line_start_q, line_start_d;
   logic               frame_start_q, frame_start_d;
   logic               hsync_q, hsync_d;
   logic               vsync_q, vsync_d;
   logic [COLOR_W-1:0] r_q, r_d, g_q, g_d, b_q, b_d;

   logic               ce;
   logic               valid;
   logic [31:0]        x_ext, y_ext;
   logic [COLOR_W-1:0] col_r, col_g, col_b;
`ifdef VGA_TEST_PATTERN_EN
   logic [2:0]         bar;
`endif

   // With CLK_DIV=1 the divider is stuck at 0 and the enable stays high.
   assign ce    = (div_q == DIV_W'(CLK_DIV - 1));
   assign x_ext = 32'(pix_x_q);
   assign y_ext = 32'(pix_y_q);
   assign valid = (x_ext < H_ACTIVE) && (y_ext < V_ACTIVE);

   always_comb begin
      col_r = r_in;
      col_g = g_in;
      col_b = b_in;
`ifdef VGA_TEST_PATTERN_EN
      bar = 3'(x_ext / BAR_W);
      if (test_en) begin
         col_r = bar[2] ? '1 : '0;
         col_g = bar[1] ? '1 : '0;
         col_b = bar[0] ? '1 : '0;
      end
`endif
      if (!valid) begin
         col_r = '0;
         col_g = '0;
         col_b = '0;
      end
   end

   always_comb begin
      div_d         = div_q;
      pix_x_d       = pix_x_q;
      pix_y_d       = pix_y_q;
      line_start_d  = 1'b0;
      frame_start_d = 1'b0;
      hsync_d       = hsync_q;
      vsync_d       = vsync_q;
      r_d           = r_q;
      g_d           = g_q;
      b_d           = b_q;
      if (ce) begin
         div_d = '0;
         if (pix_x_q == X_W'(H_TOTAL - 1)) begin
            pix_x_d      = '0;
            line_start_d = 1'b1;
            if (pix_y_q == Y_W'(V_TOTAL - 1)) begin
               pix_y_d       = '0;
               frame_start_d = 1'b1;
            end else begin
               pix_y_d = pix_y_q + 1'b1;
            end
         end else begin
            pix_x_d = pix_x_q + 1'b1;
         end
         // Output stage samples the coordinate being left, hence one tick of lag.
         hsync_d = ((x_ext >= H_ACTIVE + H_FP) && (x_ext < H_ACTIVE + H_FP + H_SYNC))
                   ? HSYNC_POL : ~HSYNC_POL;
         vsync_d = ((y_ext >= V_ACTIVE + V_FP) && (y_ext < V_ACTIVE + V_FP + V_SYNC))
                   ? VSYNC_POL : ~VSYNC_POL;
         r_d = col_r;
         g_d = col_g;
         b_d = col_b;
      end else begin
         div_d = div_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         div_q         <= '0;
         pix_x_q       <= '0;
         pix_y_q       <= '0;
         line_start_q  <= 1'b0;
         frame_start_q <= 1'b0;
         hsync_q       <= ~HSYNC_POL;
         vsync_q       <= ~VSYNC_POL;
         r_q           <= '0;
         g_q           <= '0;
         b_q           <= '0;
      end else begin
         div_q         <= div_d;
         pix_x_q       <= pix_x_d;
         pix_y_q       <= pix_y_d;
         line_start_q  <= line_start_d;
         frame_start_q <= frame_start_d;
         hsync_q       <= hsync_d;
         vsync_q       <= vsync_d;
         r_q           <= r_d;
         g_q           <= g_d;
         b_q           <= b_d;
      end
   end

   assign pix_x       = pix_x_q;
   assign pix_y       = pix_y_q;
   assign pix_valid   = valid;
   assign pix_ce      = ce;
   assign line_start  = line_start_q;
   assign frame_start = frame_start_q;
   assign hsync       = hsync_q;
   assign vsync       = vsync_q;
   assign r           = r_q;
   assign g           = g_q;
   assign b           = b_q;

endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Parametrised VGA timing generator and pixel output stage for the pac_man display path. It derives a pixel-rate enable from the system clock and runs horizontal and vertical counters over a configurable mode. It presents the current pixel coordinate to the game renderer and registers the renderer's colour together with hsync/vsync, blanking colour outside the active area. It generalises the fixed 2-bit-per-channel VGA output into any resolution, sync polarity, clock ratio and colour depth.

## Interface
- CLK_DIV, 2: system clocks per pixel (1..16); 50 MHz / 2 = 25 MHz pixel rate.
- H_ACTIVE, 640 / H_FP, 16 / H_SYNC, 96 / H_BP, 48: horizontal segment lengths in pixels; H_TOTAL = sum (800).
- V_ACTIVE, 480 / V_FP, 10 / V_SYNC, 2 / V_BP, 33: vertical segment lengths in lines; V_TOTAL = sum (525).
- HSYNC_POL, 0 / VSYNC_POL, 0: active sync level (0 = active-low).
- COLOR_W, 2: bits per colour channel.
- clk  in  1  system clock; all logic on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- r_in, g_in, b_in  in  COLOR_W each  renderer colour for the pixel at (pix_x, pix_y).
- pix_x  out  clog2(H_TOTAL)  horizontal counter.
- pix_y  out  clog2(V_TOTAL)  vertical counter.
- pix_valid  out  1  pix_x < H_ACTIVE and pix_y < V_ACTIVE.
- pix_ce  out  1  one-clk pixel enable.
- line_start, frame_start  out  1  one-clk pulses.
- hsync, vsync  out  1  sync outputs, registered.
- r, g, b  out  COLOR_W each  registered colour, zero when blanked.

## Operation
- Divider: a counter runs 0..CLK_DIV-1. pix_ce is high for one clk when it equals CLK_DIV-1. With CLK_DIV=1, pix_ce is held high.
- On each pix_ce, pix_x increments. At H_TOTAL-1 it wraps to 0 and pix_y increments. pix_y wraps from V_TOTAL-1 to 0.
- Output stage updates on pix_ce only, from the pre-increment counter values:
  - hsync = HSYNC_POL when H_ACTIVE+H_FP <= pix_x < H_ACTIVE+H_FP+H_SYNC, else ~HSYNC_POL.
  - vsync = VSYNC_POL when V_ACTIVE+V_FP <= pix_y < V_ACTIVE+V_FP+V_SYNC, else ~VSYNC_POL.
  - r/g/b = r_in/g_in/b_in when pix_valid, else 0.
- line_start pulses on the clk in which pix_x becomes 0. frame_start pulses when pix_x and pix_y both become 0. frame_start always coincides with a line_start pulse.
- Reset, whether asserted idle or mid-frame, forces:
  - divider, pix_x and pix_y to 0;
  - hsync = ~HSYNC_POL, vsync = ~VSYNC_POL;
  - r/g/b = 0, line_start = frame_start = 0.
- After rst_n deasserts, counting restarts at (0,0). No start pulse is issued for the reset-initial (0,0); the first frame_start occurs at the first wrap.
- Parameter legality: every segment length must be at least 1 and CLK_DIV must be at least 1. The generator does not check these; illegal values give undefined behaviour.

## Timing
- pix_x, pix_y and pix_valid change only on the clk edge where pix_ce=1. They are stable for CLK_DIV clocks.
- The renderer has CLK_DIV clocks, minus routing, to drive the colour for (pix_x, pix_y). The colour is sampled on the next pix_ce edge.
- Output latency: hsync, vsync and rgb for coordinate (x,y) appear one pixel tick after pix_x/pix_y show (x,y), i.e. CLK_DIV clocks. All five outputs are aligned with each other.
- The line period is exactly H_TOTAL × CLK_DIV clocks. The frame period is H_TOTAL × V_TOTAL × CLK_DIV clocks.
- Sync and blanking transitions occur only on pix_ce edges. Outputs are glitch-free because they are register outputs.

## Configuration
- VGA_TEST_PATTERN_EN defined:
  - Adds input test_en (1 bit).
  - When test_en=1, r_in/g_in/b_in are ignored. The active area shows eight vertical colour bars, each H_ACTIVE/8 pixels wide.
  - Bar k (k = pix_x / (H_ACTIVE/8)) has r = all-ones if k[2], g = all-ones if k[1], b = all-ones if k[0].
  - Blanking and sync behaviour are unchanged.
  - test_en is sampled on pix_ce like the colour inputs.
- Not defined: no test_en port and no pattern logic; the colour comes from the renderer only.

## Test plan
- Reset values: assert rst_n=0 with defaults.
  - Required: hsync=1, vsync=1, r=g=b=0, pix_x=pix_y=0, no pulses.
  - After release: first pix_ce 2 clks later; frame_start first fires after 800×525×2 = 840000 clks.
- Horizontal timing: with defaults, measure one line.
  - Required: hsync low for exactly 96 pixel ticks (192 clks).
  - The hsync falling edge lags pix_x=656 by one tick.
  - The line period is 1600 clks.
- Vertical timing: with defaults, run a full frame.
  - Required: vsync low while pix_y=490..491, delayed by one tick (2 lines = 3200 clks).
  - frame_start spacing is 840000 clks.
- Blanking: drive r_in=g_in=b_in=2'b11 constantly.
  - Required: rgb=3 only for the 640×480 active area, lagging one tick.
  - rgb=0 on pix_x=640..799 and pix_y=480..524.
- Parameter variant: CLK_DIV=1, HSYNC_POL=1, tiny mode with H=4/1/2/1 and V=3/1/1/1.
  - Required: pix_ce constantly high and line period 8 clks.
  - hsync high for 2 clks at x=5..6, delayed by one tick.
- Reset mid-frame: assert rst_n at pix_x=300, pix_y=200.
  - Required: immediate return to reset values, without waiting for a clk edge.
  - Counting restarts from (0,0).
  - With VGA_TEST_PATTERN_EN and test_en=1, bar 5 shows r=3, g=0, b=3 (pix_x=400..479, lagging one tick).
